// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner for a packed BCD digit bus.
// Latches the digits once per frame and inserts one blank cycle between digits.
module bcd_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    CLK,
    input  logic                    MR,
    input  logic [4*NUM_DIGITS-1:0] BCD,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic                    BLANK_LZ,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic                    FRAME
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    primed_q, primed_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_q, frame_d;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   lz_mask;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // lz_mask[k] is set when digits NUM_DIGITS-1 down to k are all zero
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run        = run & (snap_q[4*k +: 4] == 4'd0);
            lz_mask[k] = run;
        end
    end

    always_comb begin
        tick      = (pre_q == PRE_LAST);
        wrap      = tick && (idx_q == IDX_LAST);

        pre_d     = tick ? '0 : pre_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;
        if (wrap || !primed_q) begin
            snap_d    = BCD;
            snap_dp_d = DP_IN;
        end
        primed_d  = 1'b1;
        frame_d   = wrap;

        cur_digit = snap_q[{idx_q, 2'b00} +: 4];
        an_d      = '0;
        seg_d     = '0;
        dp_d      = 1'b0;
        if (pre_q != '0) begin
            an_d[idx_q] = 1'b1;
            dp_d        = snap_dp_q[idx_q];
            if (BLANK_LZ && (idx_q != '0) && lz_mask[idx_q]) begin
                seg_d = 7'h00;
            end else begin
                seg_d = decode(cur_digit);
            end
        end
    end

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            pre_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            snap_dp_q <= '0;
            primed_q  <= 1'b0;
            an_q      <= '0;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            primed_q  <= primed_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DP    = dp_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: a cycle-count reference model
// queues the expected outputs per edge and a monitor pops and compares.
module tb_bcd_display_scanner;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int FL = N * R;

    logic         CLK = 1'b0;
    logic         MR  = 1'b1;
    logic [4*N-1:0] BCD = '0;
    logic [N-1:0] DP_IN = '0;
    logic         BLANK_LZ = 1'b0;
    logic [N-1:0] AN;
    logic [6:0]   SEG;
    logic         DP;
    logic         FRAME;

    bcd_display_scanner #(
        .NUM_DIGITS(N),
        .REFRESH_DIV(R)
    ) dut (
        .CLK(CLK),
        .MR(MR),
        .BCD(BCD),
        .DP_IN(DP_IN),
        .BLANK_LZ(BLANK_LZ),
        .AN(AN),
        .SEG(SEG),
        .DP(DP),
        .FRAME(FRAME)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic         frame;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                                 7'h40, 7'h40, 7'h40, 7'h40};

    // Model state: cycles since reset release and the latched frame contents
    int           c_m = 0;
    bit           primed_m = 0;
    logic [4*N-1:0] snap_m = '0;
    logic [N-1:0] sdp_m = '0;

    function automatic logic [6:0] ref_seg(input logic [4*N-1:0] s,
                                           input int i, input logic blz);
        bit lead;
        lead = 1;
        for (int k = N - 1; k >= i; k--)
            if (s[4*k +: 4] != 4'd0) lead = 0;
        if (blz && i > 0 && lead) return 7'h00;
        return seg_tab[s[4*i +: 4]];
    endfunction

    always @(posedge CLK) begin : model
        obs_t e;
        int   pre, idx;
        e = '0;
        if (MR) begin
            c_m      = 0;
            primed_m = 0;
            snap_m   = '0;
            sdp_m    = '0;
        end else begin
            pre = c_m % R;
            idx = (c_m / R) % N;
            if (pre != 0) begin
                e.an[idx] = 1'b1;
                e.seg     = ref_seg(snap_m, idx, BLANK_LZ);
                e.dp      = sdp_m[idx];
            end
            e.frame = (c_m % FL == FL - 1);
            if (!primed_m || (c_m % FL == FL - 1)) begin
                snap_m = BCD;
                sdp_m  = DP_IN;
            end
            primed_m = 1;
            c_m++;
        end
        exp_q.push_back(e);
    end

    always @(posedge CLK) begin : monitor
        obs_t e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{AN, SEG, DP, FRAME};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scan t=%0t got AN=%b SEG=%h DP=%b FRAME=%b want AN=%b SEG=%h DP=%b FRAME=%b",
                         $time, a.an, a.seg, a.dp, a.frame,
                         e.an, e.seg, e.dp, e.frame);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Release at a negedge, then check first two edges directly
    task automatic release_chk();
        MR = 1'b0;
        @(posedge CLK);
        #2;
        chk("rel_edge1_an", 32'(AN), 32'h0);
        chk("rel_edge1_frame", 32'(FRAME), 32'h0);
        @(posedge CLK);
        #2;
        chk("rel_edge2_an", 32'(AN), 32'h1);
    endtask

    task automatic mid_reset();
        @(posedge CLK);
        #2;
        MR = 1'b1;
        #1;
        chk("async_rst", 32'({AN, SEG, DP, FRAME}), 32'h0);
        cyc(2);
    endtask

    task automatic wait_an(input logic [N-1:0] v);
        bit found;
        found = 0;
        for (int i = 0; i < 4 * FL && !found; i++) begin
            @(negedge CLK);
            if (AN == v) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_an got %b want %b", AN, v);
        end
    endtask

    function automatic logic [4*N-1:0] rand_bcd();
        logic [4*N-1:0] b;
        for (int d = 0; d < N; d++)
            b[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0
                                                      : 4'($urandom_range(0, 15));
        return b;
    endfunction

    initial begin
        BCD = 16'h1234;
        cyc(3);
        release_chk();
        cyc(3 * FL);

        BCD = 16'h0070;
        BLANK_LZ = 1'b1;
        cyc(2 * FL + 3);
        BCD = 16'h0000;
        cyc(2 * FL);
        BLANK_LZ = 1'b0;
        cyc(2 * FL);

        BCD = 16'h1234;
        cyc(2 * FL);
        wait_an(4'b0010);
        BCD = 16'h5678;
        cyc(3 * FL);

        BCD = 16'h0A05;
        BLANK_LZ = 1'b1;
        DP_IN = 4'b0010;
        cyc(3 * FL);

        BCD = 16'h9999;
        DP_IN = '0;
        cyc(2 * FL);
        wait_an(4'b0100);
        mid_reset();
        release_chk();
        cyc(2 * FL);

        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 29) == 0) BCD = rand_bcd();
            if ($urandom_range(0, 59) == 0) BLANK_LZ = ~BLANK_LZ;
            if ($urandom_range(0, 39) == 0) DP_IN = N'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                mid_reset();
                release_chk();
            end
        end
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
